// File: rtl/tiny86_trace_seq.sv
// tiny86_trace_seq
//  Streaming front-end for the tiny86 step checker. Trace steps are buffered
//  in a FIFO, presented one at a time to the combinational step core, and the
//  core's post-state registers for step N are chained against the pre-state
//  registers of step N+1. A sticky pass/fault verdict is raised once per trace.
//
//  Optional build macro: TINY86_SEQ_PIPE_EN
//   defined   : core_o_regs is registered; the comparison happens in a CHECK
//               state one cycle after RUN (1 step per 2 clk).
//   undefined : comparison is combinational in RUN (1 step per clk).
//
//  Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready/in_step/in_last   upstream step stream
//   core_valid/core_step                step under evaluation by the core
//   core_o_regs     core post-state regs (eax..ebp,eip,eflags; eflags [31:0])
//   done/pass/fault sticky verdict
//   fault_step_idx  index of the step whose successor mismatched
//   steps_checked   number of successful chain comparisons
//
//  state | meaning
//  IDLE  | waiting for the first step of the trace
//  RUN   | cur step driven to the core (compare here when not pipelined)
//  CHECK | registered core result compared with FIFO head (pipelined only)
//  DONE  | trace ended on its last step, chain intact
//  FAULT | chain mismatch found
module tiny86_trace_seq #(
    parameter int          STEP_W      = 560,
    parameter int          REGS_LSB    = 144,
    parameter int          DEPTH       = 8,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] EFLAGS_MASK = 32'h0000_08D5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [STEP_W-1:0] in_step,
    input  logic              in_last,
    output logic              core_valid,
    output logic [STEP_W-1:0] core_step,
    input  logic [319:0]      core_o_regs,
    output logic              done,
    output logic              pass,
    output logic              fault,
    output logic [CNT_W-1:0]  fault_step_idx,
    output logic [CNT_W-1:0]  steps_checked
);

    localparam int AW = $clog2(DEPTH);

`ifdef TINY86_SEQ_PIPE_EN
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_DONE, S_FAULT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DONE, S_FAULT} state_t;
`endif

    state_t state, state_d;

    logic [STEP_W:0]     mem [DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                full, empty, push, pop;
    logic [STEP_W:0]     head;
    logic [319:0]        head_regs, cmp_regs;
    logic                regs_match;

    logic [STEP_W-1:0]   cur_step;
    logic                cur_last;
    logic [CNT_W-1:0]    cur_idx;
    logic                inc_checked, set_fault, ready_st;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_regs = head[REGS_LSB +: 320];

`ifdef TINY86_SEQ_PIPE_EN
    logic [319:0] o_regs_q;
    assign cmp_regs = o_regs_q;
`else
    assign cmp_regs = core_o_regs;
`endif

    // GPRs and eip exact; only the arithmetic flags of eflags take part.
    assign regs_match = (head_regs[319:32] == cmp_regs[319:32]) &&
                        (((head_regs[31:0] ^ cmp_regs[31:0]) & EFLAGS_MASK) == 32'h0);

    assign in_ready = ready_st && !full && !rst;
    assign push     = in_valid && in_ready;

    assign core_step = cur_step;
    assign done      = (state == S_DONE) || (state == S_FAULT);
    assign pass      = (state == S_DONE);
    assign fault     = (state == S_FAULT);

    always_comb begin
        state_d     = state;
        pop         = 1'b0;
        inc_checked = 1'b0;
        set_fault   = 1'b0;
        core_valid  = 1'b0;
        ready_st    = 1'b0;
        case (state)
            S_IDLE: begin
                ready_st = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_RUN;
                end
            end
`ifdef TINY86_SEQ_PIPE_EN
            S_RUN: begin
                ready_st   = 1'b1;
                core_valid = 1'b1;
                state_d    = S_CHECK;
            end
            S_CHECK: begin
`else
            S_RUN: begin
`endif
                ready_st   = 1'b1;
                core_valid = 1'b1;
                if (cur_last) begin
                    state_d = S_DONE;
                end else if (!empty) begin
                    if (regs_match) begin
                        pop         = 1'b1;
                        inc_checked = 1'b1;
                        state_d     = S_RUN;
                    end else begin
                        set_fault = 1'b1;
                        state_d   = S_FAULT;
                    end
                end
            end
            S_DONE, S_FAULT: ;
            default: state_d = S_IDLE;
        endcase
    end

    // Storage array carries no reset; emptiness is defined by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_step};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cur_step       <= '0;
            cur_last       <= 1'b0;
            cur_idx        <= '0;
            steps_checked  <= '0;
            fault_step_idx <= '0;
`ifdef TINY86_SEQ_PIPE_EN
            o_regs_q       <= '0;
`endif
        end else begin
            state <= state_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                cur_step <= head[STEP_W-1:0];
                cur_last <= head[STEP_W];
                cur_idx  <= (state == S_IDLE) ? '0 : sat_inc(cur_idx);
            end
            if (inc_checked) steps_checked  <= sat_inc(steps_checked);
            if (set_fault)   fault_step_idx <= cur_idx;
`ifdef TINY86_SEQ_PIPE_EN
            if (state == S_RUN) o_regs_q <= core_o_regs;
`endif
        end
    end

endmodule

// File: tb/tb_tiny86_trace_seq.sv
module tb_tiny86_trace_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [559:0] in_step = '0;
    logic         in_last = 1'b0;
    logic         core_valid;
    logic [559:0] core_step;
    logic [319:0] core_o_regs;
    logic         done, pass, fault;
    logic [31:0]  fault_step_idx, steps_checked;

    int n_checks = 0;
    int n_errors = 0;

    logic [559:0] tr_step [16];
    logic         tr_last [16];
    int           tr_n;

    logic        exp_pass, exp_fault;
    logic [31:0] exp_idx, exp_steps;

    always #5 clk = ~clk;

    tiny86_trace_seq #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_step(in_step), .in_last(in_last),
        .core_valid(core_valid), .core_step(core_step), .core_o_regs(core_o_regs),
        .done(done), .pass(pass), .fault(fault),
        .fault_step_idx(fault_step_idx), .steps_checked(steps_checked)
    );

    // Stand-in for the combinational tiny86 core: some deterministic function of the step.
    function automatic logic [319:0] core_fn(input logic [559:0] s);
        logic [319:0] r;
        logic [95:0]  ins;
        r   = s[463:144];
        ins = s[559:464];
        return {r[318:0], r[319]} ^ {ins, ins, ins, ins[31:0]};
    endfunction

    assign core_o_regs = core_fn(core_step);

    function automatic bit chain_ok(input logic [319:0] nxt, input logic [319:0] post);
        return (nxt[319:32] == post[319:32]) &&
               ((nxt[31:0] & 32'h0000_08D5) == (post[31:0] & 32'h0000_08D5));
    endfunction

    function automatic logic [559:0] rand_step();
        logic [559:0] s;
        s = '0;
        for (int i = 0; i < 18; i++) s = {s[527:0], 32'($urandom())};
        return s;
    endfunction

    task automatic build_chain(input int n);
        tr_n = n;
        tr_step[0] = rand_step();
        tr_last[0] = (n == 1);
        for (int i = 1; i < n; i++) begin
            tr_step[i] = rand_step();
            tr_step[i][463:144] = core_fn(tr_step[i-1]);
            tr_last[i] = (i == n - 1);
        end
    endtask

    // Walk the trace by the chain rule and derive the verdict.
    task automatic model_eval();
        exp_pass = 0; exp_fault = 0; exp_idx = 0; exp_steps = 0;
        for (int i = 0; i < tr_n; i++) begin
            if (tr_last[i]) begin
                exp_pass = 1; exp_steps = 32'(i);
                return;
            end
            if (!chain_ok(tr_step[i+1][463:144], core_fn(tr_step[i]))) begin
                exp_fault = 1; exp_idx = 32'(i); exp_steps = 32'(i);
                return;
            end
        end
    endtask

    task automatic do_reset();
        in_valid = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // Called right after a negedge: presents the next step and notes acceptance.
    task automatic drive_step(input bit gaps, inout int idx, inout int drops);
        if (idx < tr_n && (!gaps || $urandom_range(3) != 0)) begin
            in_valid = 1;
            in_step  = tr_step[idx];
            in_last  = tr_last[idx];
        end else begin
            in_valid = 0;
        end
        if (in_valid && !in_ready) drops++;
        if (in_valid && in_ready) idx++;
    endtask

    task automatic run_trace(input string name, input bit gaps, output int acc, output int drops);
        int idx;
        bit seen_done;
        idx = 0; drops = 0; seen_done = 0;
        model_eval();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (done) begin
                seen_done = 1;
                break;
            end
            drive_step(gaps, idx, drops);
        end
        in_valid = 0;
        acc = idx;
        n_checks++;
        if (seen_done !== 1'b1) begin
            n_errors++; $display("FAIL %s done timeout: got done=%0b want 1", name, done);
        end
        n_checks++;
        if (pass !== exp_pass) begin
            n_errors++; $display("FAIL %s pass: got %0b want %0b", name, pass, exp_pass);
        end
        n_checks++;
        if (fault !== exp_fault) begin
            n_errors++; $display("FAIL %s fault: got %0b want %0b", name, fault, exp_fault);
        end
        n_checks++;
        if (fault_step_idx !== exp_idx) begin
            n_errors++; $display("FAIL %s fault_step_idx: got %0d want %0d", name, fault_step_idx, exp_idx);
        end
        n_checks++;
        if (steps_checked !== exp_steps) begin
            n_errors++; $display("FAIL %s steps_checked: got %0d want %0d", name, steps_checked, exp_steps);
        end
        n_checks++;
        if (core_valid !== 1'b0) begin
            n_errors++; $display("FAIL %s core_valid after verdict: got %0b want 0", name, core_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        in_valid = 1;
        #3;
        n_checks++;
        if ({in_ready, core_valid, done, pass, fault} !== 5'b0 || fault_step_idx !== 0 ||
            steps_checked !== 0 || core_step !== '0) begin
            n_errors++;
            $display("FAIL reset outputs: got rdy=%0b cv=%0b done=%0b pass=%0b fault=%0b idx=%0d chk=%0d want all 0",
                     in_ready, core_valid, done, pass, fault, fault_step_idx, steps_checked);
        end
        do_reset();
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            n_errors++; $display("FAIL post-reset idle: got rdy=%0b done=%0b want rdy=1 done=0", in_ready, done);
        end
    endtask

    task automatic test_chain3();
        int acc, drops;
        do_reset();
        build_chain(3);
        run_trace("chain3", 0, acc, drops);
    endtask

    task automatic test_eax_fault();
        int acc, drops;
        do_reset();
        build_chain(3);
        tr_step[1][463:432] = tr_step[1][463:432] + 32'd1;
        run_trace("eax_fault", 0, acc, drops);
    endtask

    task automatic test_eflags();
        int acc, drops;
        do_reset();
        build_chain(2);
        tr_step[1][175:144] = tr_step[1][175:144] ^ 32'h2;
        run_trace("eflags_bit1_ignored", 0, acc, drops);
        do_reset();
        build_chain(2);
        tr_step[1][175:144] = tr_step[1][175:144] ^ 32'h1;
        run_trace("eflags_cf", 0, acc, drops);
    endtask

    task automatic test_back_to_back();
        int acc, drops;
        do_reset();
        build_chain(10);
        run_trace("back_to_back", 0, acc, drops);
        n_checks++;
        if (acc !== 10) begin
            n_errors++; $display("FAIL back_to_back accepted: got %0d want 10", acc);
        end
`ifdef TINY86_SEQ_PIPE_EN
        n_checks++;
        if (drops == 0) begin
            n_errors++; $display("FAIL back_to_back backpressure: got %0d stalled cycles want >0", drops);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int idx, drops, acc;
        bit reached;
        do_reset();
        build_chain(8);
        idx = 0; drops = 0; reached = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (steps_checked >= 2) begin
                reached = 1;
                break;
            end
            drive_step(0, idx, drops);
        end
        n_checks++;
        if (!reached || done !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid reach: got chk=%0d done=%0b want chk>=2 done=0", steps_checked, done);
        end
        in_valid = 0;
        #2 rst = 1;
        #1;
        n_checks++;
        if ({in_ready, core_valid, done, pass, fault} !== 5'b0 || fault_step_idx !== 0 ||
            steps_checked !== 0 || core_step !== '0) begin
            n_errors++;
            $display("FAIL reset_mid async clear: got rdy=%0b cv=%0b done=%0b chk=%0d want all 0",
                     in_ready, core_valid, done, steps_checked);
        end
        repeat (2) @(negedge clk);
        rst = 0;
        build_chain(2);
        run_trace("after_reset", 0, acc, drops);
    endtask

    task automatic test_hold_after_done();
        int acc, drops;
        do_reset();
        build_chain(3);
        run_trace("hold_setup", 0, acc, drops);
        in_valid = 1;
        in_step  = rand_step();
        in_last  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || done !== 1'b1 || pass !== exp_pass || fault !== exp_fault ||
                steps_checked !== exp_steps || fault_step_idx !== exp_idx) begin
                n_errors++;
                $display("FAIL hold_after_done cyc %0d: got rdy=%0b done=%0b pass=%0b chk=%0d want rdy=0 done=1 pass=%0b chk=%0d",
                         c, in_ready, done, pass, steps_checked, exp_pass, exp_steps);
            end
        end
        in_valid = 0;
    endtask

    task automatic test_random();
        int acc, drops, n, j;
        for (int t = 0; t < 10; t++) begin
            do_reset();
            n = $urandom_range(7, 1);
            build_chain(n);
            if (n > 1 && $urandom_range(1) == 1) begin
                j = $urandom_range(n - 1, 1);
                case ($urandom_range(3))
                    0: tr_step[j][463:432] = tr_step[j][463:432] + 32'd1;
                    1: tr_step[j][175:144] = tr_step[j][175:144] ^ 32'h0000_0800;
                    2: tr_step[j][175:144] = tr_step[j][175:144] ^ 32'h0000_0100;
                    default: tr_step[j][207:176] = tr_step[j][207:176] ^ 32'h0000_0004;
                endcase
            end
            run_trace($sformatf("random%0d", t), 1, acc, drops);
        end
    endtask

    initial begin
        test_reset();
        test_chain3();
        test_eax_fault();
        test_eflags();
        test_back_to_back();
        test_reset_mid();
        test_hold_after_done();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
